// File: rtl/pipeline_fifo_burst_arbiter.sv
// Round-robin burst arbiter merging INPUT_COUNT ready/valid streams into one port.
// The output passes through a 2-entry skid stage, so input_ready never depends on output_ready.
module pipeline_fifo_burst_arbiter #(
    parameter int unsigned INPUT_COUNT  = 4,
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned BURST_LENGTH = 4
) (
    input  logic                                  clock,
    input  logic                                  clear,
    input  logic [INPUT_COUNT-1:0]                input_valid,
    output logic [INPUT_COUNT-1:0]                input_ready,
    input  logic [INPUT_COUNT*WORD_WIDTH-1:0]     input_data,
    output logic                                  output_valid,
    input  logic                                  output_ready,
    output logic [WORD_WIDTH-1:0]                 output_data,
    output logic [$clog2(INPUT_COUNT)-1:0]        output_source,
    output logic                                  grant_active
);

    localparam int unsigned IW = $clog2(INPUT_COUNT);
    localparam int unsigned CW = $clog2(BURST_LENGTH + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LENGTH - 1);
    localparam logic [IW-1:0] LAST_SRC  = IW'(INPUT_COUNT - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_grant_index;
    logic [IW-1:0]         w_grant_nxt;
    logic [IW-1:0]         r_last_index;
    logic [IW-1:0]         w_last_nxt;
    logic [CW-1:0]         r_burst_count;
    logic [CW-1:0]         w_count_nxt;

    logic                  r_main_valid;
    logic [WORD_WIDTH-1:0] r_main_data;
    logic [IW-1:0]         r_main_src;
    logic                  r_skid_full;
    logic [WORD_WIDTH-1:0] r_skid_data;
    logic [IW-1:0]         r_skid_src;

    logic                  w_sel_valid;
    logic [WORD_WIDTH-1:0] w_sel_data;
    logic                  w_xfer;
    logic                  w_release;
    logic [IW-1:0]         w_pick_base;
    logic [IW-1:0]         w_pick;
    logic                  w_pick_found;

    // Mux the granted source's valid and data
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            if (r_grant_index == IW'(i)) begin
                w_sel_valid = input_valid[i];
                w_sel_data  = input_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Ready decoded purely from registered state
    always_comb begin
        input_ready = '0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            input_ready[i] = (r_state == S_GRANTED) && !r_skid_full && (r_grant_index == IW'(i));
        end
    end

    assign w_xfer    = (r_state == S_GRANTED) && w_sel_valid && !r_skid_full;
    assign w_release = (r_state == S_GRANTED) &&
                       ((w_xfer && (r_burst_count == LAST_BEAT)) || (!w_sel_valid && !r_skid_full));

    // Round-robin search starting after the base index; the base itself is the last candidate
    always_comb begin
        w_pick_base  = (r_state == S_GRANTED) ? r_grant_index : r_last_index;
        w_pick       = '0;
        w_pick_found = 1'b0;
        for (int unsigned k = 1; k <= INPUT_COUNT; k++) begin
            if (!w_pick_found && input_valid[IW'((32'(w_pick_base) + k) % INPUT_COUNT)]) begin
                w_pick       = IW'((32'(w_pick_base) + k) % INPUT_COUNT);
                w_pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state       <= S_IDLE;
            r_grant_index <= '0;
            r_last_index  <= LAST_SRC;
            r_burst_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_index <= w_grant_nxt;
            r_last_index  <= w_last_nxt;
            r_burst_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_index;
        w_last_nxt  = r_last_index;
        w_count_nxt = r_burst_count;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = S_GRANTED;
                    w_grant_nxt = w_pick;
                    w_count_nxt = '0;
                end
            end
            S_GRANTED: begin
                if (w_xfer) begin
                    w_count_nxt = r_burst_count + CW'(1);
                end
                // Hand over without a bubble when another requester is waiting
                if (w_release) begin
                    w_last_nxt  = r_grant_index;
                    w_count_nxt = '0;
                    if (w_pick_found) begin
                        w_grant_nxt = w_pick;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Main/skid output stage: skid only fills when main is stalled
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_src   <= '0;
            r_skid_full  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_src   <= '0;
        end else if (r_skid_full) begin
            if (output_ready) begin
                r_main_data <= r_skid_data;
                r_main_src  <= r_skid_src;
                r_skid_full <= 1'b0;
            end
        end else if (w_xfer) begin
            if (!r_main_valid || output_ready) begin
                r_main_valid <= 1'b1;
                r_main_data  <= w_sel_data;
                r_main_src   <= r_grant_index;
            end else begin
                r_skid_full <= 1'b1;
                r_skid_data <= w_sel_data;
                r_skid_src  <= r_grant_index;
            end
        end else if (output_ready) begin
            r_main_valid <= 1'b0;
        end
    end

    assign output_valid  = r_main_valid;
    assign output_data   = r_main_data;
    assign output_source = r_main_src;
    assign grant_active  = (r_state == S_GRANTED);

endmodule

// File: tb/tb_pipeline_fifo_burst_arbiter.sv
// Bench for pipeline_fifo_burst_arbiter: queue-based sources and output-stage model,
// directed scenarios plus randomized traffic, and a BURST_LENGTH=1 instance.
module tb_pipeline_fifo_burst_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned BL    = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned VW    = 2 + N + W + IW;

    logic           clock;
    logic           clear;
    logic [N-1:0]   input_valid;
    logic [N-1:0]   input_ready;
    logic [N*W-1:0] input_data;
    logic           output_valid;
    logic           output_ready;
    logic [W-1:0]   output_data;
    logic [IW-1:0]  output_source;
    logic           grant_active;

    logic [N-1:0]   b1_input_valid;
    logic [N-1:0]   b1_input_ready;
    logic [N*W-1:0] b1_input_data;
    logic           b1_output_valid;
    logic           b1_output_ready;
    logic [W-1:0]   b1_output_data;
    logic [IW-1:0]  b1_output_source;
    logic           b1_grant_active;

    int checks   = 0;
    int failures = 0;

    // Source FIFOs feeding the arbiter
    logic [W-1:0] src_mem [N][DEPTH];
    int           src_head [N];
    int           src_tail [N];
    logic [N-1:0] src_en;

    // Reference model: grant holder plus the words sitting in the output stage
    bit              m_active;
    int              m_idx;
    int              m_last;
    int              m_cnt;
    logic [W+IW-1:0] mq [$];

    pipeline_fifo_burst_arbiter #(.INPUT_COUNT(N), .WORD_WIDTH(W), .BURST_LENGTH(BL)) u_dut (
        .clock(clock), .clear(clear),
        .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_data(output_data), .output_source(output_source),
        .grant_active(grant_active)
    );

    pipeline_fifo_burst_arbiter #(.INPUT_COUNT(N), .WORD_WIDTH(W), .BURST_LENGTH(1)) u_dut_b1 (
        .clock(clock), .clear(clear),
        .input_valid(b1_input_valid), .input_ready(b1_input_ready), .input_data(b1_input_data),
        .output_valid(b1_output_valid), .output_ready(b1_output_ready),
        .output_data(b1_output_data), .output_source(b1_output_source),
        .grant_active(b1_grant_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int pick(logic [N-1:0] iv, int last);
        for (int k = 1; k <= N; k++) begin
            if (iv[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] r;
        r = '0;
        if (m_active && mq.size() < 2) r[m_idx] = 1'b1;
        return {m_active, r, (mq.size() > 0), ((mq.size() > 0) ? mq[0] : (W+IW)'(0))};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {grant_active, input_ready, output_valid,
                (output_valid ? {output_data, output_source} : (W+IW)'(0))};
    endfunction

    task automatic fill(int s, int n, int base);
        for (int k = 0; k < n; k++) begin
            src_mem[s][src_tail[s]] = W'(base + k);
            src_tail[s]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            input_valid[i]      = src_en[i] && (src_head[i] != src_tail[i]);
            input_data[i*W +: W] = (src_head[i] != src_tail[i]) ? src_mem[i][src_head[i]] : '0;
        end
    endtask

    // One clock: advance model from the pre-edge inputs, then land on the falling edge
    task automatic cyc();
        logic [N-1:0] iv;
        bit xfer, room;
        int s;
        drive();
        iv   = input_valid;
        room = mq.size() < 2;
        xfer = m_active && iv[m_idx] && room;
        if (output_ready && mq.size() > 0) void'(mq.pop_front());
        if (xfer) begin
            mq.push_back({src_mem[m_idx][src_head[m_idx]], IW'(m_idx)});
            src_head[m_idx]++;
        end
        if (!m_active) begin
            s = pick(iv, m_last);
            if (s >= 0) begin
                m_active = 1'b1;
                m_idx    = s;
                m_cnt    = 0;
            end
        end else if ((xfer && m_cnt == BL - 1) || (!iv[m_idx] && room)) begin
            m_last = m_idx;
            m_cnt  = 0;
            s      = pick(iv, m_last);
            if (s >= 0) m_idx = s;
            else        m_active = 1'b0;
        end else if (xfer) begin
            m_cnt++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        clear        = 1'b1;
        src_en       = '0;
        output_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        m_active = 1'b0;
        m_idx    = 0;
        m_last   = N - 1;
        m_cnt    = 0;
        mq.delete();
        drive();
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({grant_active, input_ready, output_valid, output_data, output_source} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0",
                     {grant_active, input_ready, output_valid, output_data, output_source});
        end
        checks++;
        if ({b1_grant_active, b1_input_ready, b1_output_valid, b1_output_data, b1_output_source} !== '0) begin
            failures++;
            $display("FAIL reset_state_b1 got=%h exp=0",
                     {b1_grant_active, b1_input_ready, b1_output_valid, b1_output_data, b1_output_source});
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0]  gd [$];
        logic [IW-1:0] gs [$];
        int            gt [$];
        do_reset();
        fill(0, 10, 1);
        src_en       = 4'b0001;
        output_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (output_valid && output_ready) begin
                gd.push_back(output_data);
                gs.push_back(output_source);
                gt.push_back(i);
            end
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (k >= gd.size() || gd[k] !== W'(k + 1) || gs[k] !== '0 || gt[k] !== k + 2) begin
                failures++;
                $display("FAIL single_word%0d got_words=%0d exp_data=%0d exp_src=0 exp_slot=%0d",
                         k, gd.size(), k + 1, k + 2);
            end
        end
    endtask

    task automatic test_fairness();
        logic [W-1:0]  gd [$];
        logic [IW-1:0] gs [$];
        int            gt [$];
        int            es;
        do_reset();
        for (int s = 0; s < N; s++) fill(s, 12, s * 16);
        src_en       = 4'b1111;
        output_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (output_valid && output_ready) begin
                gd.push_back(output_data);
                gs.push_back(output_source);
                gt.push_back(i);
            end
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL fairness cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 16; k++) begin
            es = (k / 4) % 4;
            checks++;
            if (k >= gd.size() || gs[k] !== IW'(es) || gd[k] !== W'(es * 16 + k % 4) || gt[k] !== k + 2) begin
                failures++;
                $display("FAIL fairness_word%0d got_words=%0d exp_src=%0d exp_data=%0d exp_slot=%0d",
                         k, gd.size(), es, es * 16 + k % 4, k + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] gd [$];
        do_reset();
        fill(2, 12, 1);
        src_en = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            output_ready = !(i >= 3 && i < 8);
            if (output_valid && output_ready) gd.push_back(output_data);
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL backpressure cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (i >= 3 && i < 8) begin
                checks++;
                if (output_valid !== 1'b1 || output_data !== 8'd2 || output_source !== 2'd2 || input_ready !== '0) begin
                    failures++;
                    $display("FAIL backpressure_hold cyc%0d got v=%b d=%0d s=%0d rdy=%b exp v=1 d=2 s=2 rdy=0000",
                             i, output_valid, output_data, output_source, input_ready);
                end
            end
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (k >= gd.size() || gd[k] !== W'(k + 1)) begin
                failures++;
                $display("FAIL backpressure_order%0d got_words=%0d exp_data=%0d", k, gd.size(), k + 1);
            end
        end
        checks++;
        if (gd.size() != 12) begin
            failures++;
            $display("FAIL backpressure_count got=%0d exp=12", gd.size());
        end
    endtask

    task automatic test_starvation();
        logic [IW-1:0] gs [$];
        int a     = -1;
        int moved = -1;
        bit reen  = 1'b0;
        int exp_s [10] = '{1, 1, 3, 3, 3, 3, 1, 1, 1, 1};
        do_reset();
        fill(1, 6, 8'h10);
        fill(3, 8, 8'h30);
        src_en       = 4'b1010;
        output_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (output_valid && output_ready) gs.push_back(output_source);
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL starvation cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (moved < 0 && a >= 0 && input_ready === 4'b1000) moved = i;
            if (a < 0 && src_head[1] == 2) begin
                a         = i;
                src_en[1] = 1'b0;
            end else if (!reen && !src_en[1] && m_active && m_idx == 3) begin
                src_en[1] = 1'b1;
                reen      = 1'b1;
            end
        end
        checks++;
        if (a < 0 || moved != a + 1) begin
            failures++;
            $display("FAIL starvation_handover got_cyc=%0d exp_cyc=%0d", moved, a + 1);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (k >= gs.size() || gs[k] !== IW'(exp_s[k])) begin
                failures++;
                $display("FAIL starvation_src%0d got_words=%0d exp_src=%0d", k, gs.size(), exp_s[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int s = 0; s < N; s++) fill(s, 8, s * 16);
        src_en       = 4'b1111;
        output_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) output_ready = 1'b0;
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL async_pre cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if ({output_valid, input_ready, grant_active} !== '0) begin
            failures++;
            $display("FAIL async_clear got v=%b rdy=%b g=%b exp all 0", output_valid, input_ready, grant_active);
        end
        do_reset();
        for (int s = 0; s < N; s++) fill(s, 8, s * 16);
        src_en       = 4'b1111;
        output_ready = 1'b1;
        cyc();
        checks++;
        if (grant_active !== 1'b1 || input_ready !== 4'b0001 || output_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_first_grant got g=%b rdy=%b v=%b exp g=1 rdy=0001 v=0",
                     grant_active, input_ready, output_valid);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL async_post cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        src_en = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) src_en = N'($urandom);
            output_ready = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < N; s++) begin
                if (src_tail[s] - src_head[s] < 2 && src_tail[s] < DEPTH - 1)
                    fill(s, 1, int'($urandom_range(0, 255)));
            end
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_burst1();
        logic [W-1:0]  gd [$];
        logic [IW-1:0] gs [$];
        int            gt [$];
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (b1_output_valid && b1_output_ready) begin
                gd.push_back(b1_output_data);
                gs.push_back(b1_output_source);
                gt.push_back(i);
            end
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= gs.size() || gs[k] !== IW'(k % 4) || gd[k] !== W'((k % 4) * 8'h11) || gt[k] !== k + 2) begin
                failures++;
                $display("FAIL burst1_word%0d got_words=%0d exp_src=%0d exp_slot=%0d", k, gs.size(), k % 4, k + 2);
            end
        end
    endtask

    initial begin
        clear           = 1'b1;
        output_ready    = 1'b0;
        src_en          = '0;
        input_valid     = '0;
        input_data      = '0;
        b1_input_valid  = 4'b1111;
        b1_input_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        b1_output_ready = 1'b1;
        m_active        = 1'b0;
        m_idx           = 0;
        m_last          = N - 1;
        m_cnt           = 0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_starvation();
        test_async_reset();
        test_random();
        test_burst1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
